// File: rtl/retire_trace_buffer_if.sv
// retire_trace_buffer_if
//   Drain-side stream of the retirement trace buffer. The buffer (master)
//   presents the head record with out_valid; the consumer (slave) takes it
//   by raising out_ready.
//   out_valid  buffer -> consumer  head record present
//   out_ready  consumer -> buffer  head record accepted this cycle
//   out_kind   class index 0..8, 15 for an illegal op encoding
//   out_pc     PC of the recorded instruction
//   out_addr   register index, store address or 0 for jumps
//   out_data   write data, store data or jump target
//   out_taken  jump taken flag, 0 for non-jumps
interface retire_trace_buffer_if;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_kind;
  logic [15:0] out_pc;
  logic [15:0] out_addr;
  logic [15:0] out_data;
  logic        out_taken;

  modport master (
    output out_valid, out_kind, out_pc, out_addr, out_data, out_taken,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_kind, out_pc, out_addr, out_data, out_taken,
    output out_ready
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Records one entry per retired instruction of the 16-bit CPU into a
//   circular buffer drained through a valid/ready stream. Supports per-class
//   capture filtering, stop-or-wrap overflow, freeze on halt, and saturating
//   drop / illegal-encoding counters.
//   Parameters: DEPTH (records, power of two), WRAP (0 stop, 1 overwrite),
//               CNT_W (counter width)
//   clk, reset          clock, asynchronous active-high reset
//   retired, op, pc     retirement strobe, one-hot class, PC
//   reg_waddr/reg_wdata register write index/data
//   mem_addr/mem_data   store address/data
//   jump_addr/taken     jump target / taken flag
//   halt                CPU halt, freezes capture from the next cycle on
//   filter_mask         per-class capture enable (op bit order)
//   count               occupancy
//   dropped, illegal    saturating event counters
//   frozen              capture stopped by halt
//   trace               drain stream (master side)
module retire_trace_buffer #(
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   retired,
  input  logic [8:0]             op,
  input  logic [15:0]            pc,
  input  logic [3:0]             reg_waddr,
  input  logic [15:0]            reg_wdata,
  input  logic [15:0]            mem_addr,
  input  logic [15:0]            mem_data,
  input  logic [15:0]            jump_addr,
  input  logic                   jump_taken,
  input  logic                   halt,
  input  logic [8:0]             filter_mask,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       dropped,
  output logic [CNT_W-1:0]       illegal,
  output logic                   frozen,
  retire_trace_buffer_if.master  trace
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_STEP   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_STEP   = PW'(1);

  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] data;
    logic        taken;
  } record_t;

  record_t       mem [DEPTH];
  record_t       newRec;
  record_t       headRec;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [3:0]    kindIdx;
  logic          opOneHot;
  logic          capture;
  logic          full;
  logic          pop;
  logic          writeEn;
  logic          overwrite;
  logic          dropEvent;

  assign opOneHot = (op != '0) && ((op & (op - 9'd1)) == '0);
  assign capture  = retired && !frozen && (!opOneHot || ((op & filter_mask) != '0));
  assign full     = (count == FULL_COUNT);
  assign pop      = trace.out_valid && trace.out_ready;

  // A full buffer only accepts a new record if a slot is freed by a pop in
  // the same cycle, or if wrap mode lets it evict the oldest record.
  assign writeEn   = capture && (!full || pop || WRAP);
  assign dropEvent = capture && full && !pop;
  assign overwrite = dropEvent && WRAP;

  // Class index of a one-hot op; 15 stands in for anything not one-hot.
  always_comb begin
    kindIdx = 4'd15;
    for (int i = 0; i < 9; i++) begin
      if (op[i]) kindIdx = 4'(i);
    end
  end

  // Pack the retiring instruction into a record. Illegal encodings keep
  // only their PC so the consumer can locate them.
  always_comb begin
    newRec    = '0;
    newRec.pc = pc;
    if (!opOneHot) begin
      newRec.kind = 4'd15;
    end else begin
      newRec.kind = kindIdx;
      if (op[4]) begin
        newRec.addr = mem_addr;
        newRec.data = mem_data;
      end else if (|op[8:5]) begin
        newRec.data  = jump_addr;
        newRec.taken = jump_taken;
      end else begin
        newRec.addr = {12'b0, reg_waddr};
        newRec.data = reg_wdata;
      end
    end
  end

  // Record storage needs no reset: the head is gated while empty.
  always_ff @(posedge clk) begin
    if (writeEn) mem[wrPtr] <= newRec;
  end

  // Pointers, occupancy, counters and the halt freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      dropped <= '0;
      illegal <= '0;
      frozen  <= 1'b0;
    end else begin
      if (writeEn) wrPtr <= wrPtr + PTR_STEP;
      if (pop || overwrite) rdPtr <= rdPtr + PTR_STEP;
      if (writeEn && !pop && !overwrite) begin
        count <= count + CNT_STEP;
      end else if (pop && !writeEn) begin
        count <= count - CNT_STEP;
      end
      if (dropEvent && (dropped != '1)) dropped <= dropped + 1'b1;
      if (capture && !opOneHot && (illegal != '1)) illegal <= illegal + 1'b1;
      if (halt) frozen <= 1'b1;
    end
  end

  assign headRec         = trace.out_valid ? mem[rdPtr] : '0;
  assign trace.out_valid = (count != '0);
  assign trace.out_kind  = headRec.kind;
  assign trace.out_pc    = headRec.pc;
  assign trace.out_addr  = headRec.addr;
  assign trace.out_data  = headRec.data;
  assign trace.out_taken = headRec.taken;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer
//   Directed bench for retire_trace_buffer. Two DEPTH=4 instances share the
//   retirement inputs: u0 stops when full, u1 wraps.
module tb_retire_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        retired;
  logic [8:0]  op;
  logic [15:0] pc;
  logic [3:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] jump_addr;
  logic        jump_taken;
  logic        halt;
  logic [8:0]  filter_mask;
  logic [2:0]  count0, count1;
  logic [15:0] dropped0, dropped1;
  logic [15:0] illegal0, illegal1;
  logic        frozen0, frozen1;
  int          checks = 0;
  int          failures = 0;

  retire_trace_buffer_if if0 ();
  retire_trace_buffer_if if1 ();

  retire_trace_buffer #(.DEPTH(4), .WRAP(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .retired(retired), .op(op), .pc(pc),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .mem_addr(mem_addr),
    .mem_data(mem_data), .jump_addr(jump_addr), .jump_taken(jump_taken),
    .halt(halt), .filter_mask(filter_mask), .count(count0),
    .dropped(dropped0), .illegal(illegal0), .frozen(frozen0), .trace(if0)
  );

  retire_trace_buffer #(.DEPTH(4), .WRAP(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .retired(retired), .op(op), .pc(pc),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .mem_addr(mem_addr),
    .mem_data(mem_data), .jump_addr(jump_addr), .jump_taken(jump_taken),
    .halt(halt), .filter_mask(filter_mask), .count(count1),
    .dropped(dropped1), .illegal(illegal1), .frozen(frozen1), .trace(if1)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // One retirement lasting a single cycle.
  task automatic applyStimulus(input logic [8:0] o, input logic [15:0] p,
                               input logic [15:0] a, input logic [15:0] d,
                               input logic jt, input logic h);
    retired    = 1'b1;
    op         = o;
    pc         = p;
    reg_waddr  = a[3:0];
    reg_wdata  = d;
    mem_addr   = a;
    mem_data   = d;
    jump_addr  = d;
    jump_taken = jt;
    halt       = h;
    stepClock();
    retired    = 1'b0;
    jump_taken = 1'b0;
    halt       = 1'b0;
  endtask

  task automatic popBoth();
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    stepClock();
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; retired = 1'b0; op = '0; pc = '0; reg_waddr = '0;
    reg_wdata = '0; mem_addr = '0; mem_data = '0; jump_addr = '0;
    jump_taken = 1'b0; halt = 1'b0; filter_mask = 9'h1FF;
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    stepClock();
    stepClock();
    checkOutput("rst_valid", 32'(if0.out_valid), 32'd0);
    checkOutput("rst_count", 32'(count0), 32'd0);
    checkOutput("rst_dropped", 32'(dropped0), 32'd0);
    checkOutput("rst_illegal", 32'(illegal0), 32'd0);
    checkOutput("rst_frozen", 32'(frozen0), 32'd0);
    checkOutput("rst_pc", 32'(if0.out_pc), 32'd0);
    checkOutput("rst_data", 32'(if0.out_data), 32'd0);
    checkOutput("rst_valid_wrap", 32'(if1.out_valid), 32'd0);
    reset = 1'b0;
    stepClock();

    // Single sub record, one-cycle capture latency, then pop.
    applyStimulus(9'h001, 16'h0010, 16'h0003, 16'h1234, 1'b0, 1'b0);
    checkOutput("sub_valid", 32'(if0.out_valid), 32'd1);
    checkOutput("sub_kind", 32'(if0.out_kind), 32'd0);
    checkOutput("sub_pc", 32'(if0.out_pc), 32'h0010);
    checkOutput("sub_addr", 32'(if0.out_addr), 32'h0003);
    checkOutput("sub_data", 32'(if0.out_data), 32'h1234);
    checkOutput("sub_taken", 32'(if0.out_taken), 32'd0);
    checkOutput("sub_count", 32'(count0), 32'd1);
    popBoth();
    checkOutput("pop_valid", 32'(if0.out_valid), 32'd0);
    checkOutput("pop_count", 32'(count0), 32'd0);

    // Six stores into a DEPTH=4 buffer with no consumer.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(9'h010, 16'(i), 16'(16'h0100 + i), 16'(16'hA000 + i), 1'b0, 1'b0);
    end
    checkOutput("stop_count", 32'(count0), 32'd4);
    checkOutput("stop_dropped", 32'(dropped0), 32'd2);
    checkOutput("wrap_count", 32'(count1), 32'd4);
    checkOutput("wrap_dropped", 32'(dropped1), 32'd2);
    checkOutput("st_kind", 32'(if0.out_kind), 32'd4);
    checkOutput("st_addr", 32'(if0.out_addr), 32'h0100);
    checkOutput("st_data", 32'(if0.out_data), 32'hA000);
    checkOutput("wrap_head_addr", 32'(if1.out_addr), 32'h0102);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stop_drain_pc", 32'(if0.out_pc), 32'(i));
      checkOutput("wrap_drain_pc", 32'(if1.out_pc), 32'(i + 2));
      popBoth();
    end
    checkOutput("stop_drained", 32'(if0.out_valid), 32'd0);
    checkOutput("wrap_drained", 32'(if1.out_valid), 32'd0);

    // Class filter: only jz passes; illegal encodings always pass.
    filter_mask = 9'h020;
    applyStimulus(9'h001, 16'h0020, 16'h0005, 16'h1111, 1'b0, 1'b0);
    applyStimulus(9'h020, 16'h0021, 16'h0007, 16'h0040, 1'b1, 1'b0);
    applyStimulus(9'h040, 16'h0022, 16'h0007, 16'h0050, 1'b1, 1'b0);
    applyStimulus(9'h003, 16'h0030, 16'h0077, 16'h0088, 1'b1, 1'b0);
    checkOutput("flt_count", 32'(count0), 32'd2);
    checkOutput("flt_illegal", 32'(illegal0), 32'd1);
    checkOutput("jz_kind", 32'(if0.out_kind), 32'd5);
    checkOutput("jz_pc", 32'(if0.out_pc), 32'h0021);
    checkOutput("jz_addr", 32'(if0.out_addr), 32'd0);
    checkOutput("jz_data", 32'(if0.out_data), 32'h0040);
    checkOutput("jz_taken", 32'(if0.out_taken), 32'd1);
    filter_mask = 9'h000;
    applyStimulus(9'h000, 16'h0038, 16'h0001, 16'h0002, 1'b0, 1'b0);
    checkOutput("mask0_illegal", 32'(illegal0), 32'd2);
    checkOutput("mask0_count", 32'(count0), 32'd3);
    popBoth();
    checkOutput("ill_kind", 32'(if0.out_kind), 32'd15);
    checkOutput("ill_pc", 32'(if0.out_pc), 32'h0030);
    checkOutput("ill_addr", 32'(if0.out_addr), 32'd0);
    checkOutput("ill_data", 32'(if0.out_data), 32'd0);
    checkOutput("ill_taken", 32'(if0.out_taken), 32'd0);
    popBoth();
    checkOutput("ill2_pc", 32'(if0.out_pc), 32'h0038);
    popBoth();
    checkOutput("flt_drained", 32'(if0.out_valid), 32'd0);

    // Full buffer with simultaneous push and pop for ten cycles.
    filter_mask = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(9'h010, 16'(16'h0050 + i), 16'h0200, 16'h0000, 1'b0, 1'b0);
    end
    checkOutput("full_count", 32'(count0), 32'd4);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("pp_head_pc", 32'(if0.out_pc), 32'(16'h0050 + i));
      checkOutput("pp_head_pc_wrap", 32'(if1.out_pc), 32'(16'h0050 + i));
      applyStimulus(9'h010, 16'(16'h0054 + i), 16'h0200, 16'h0000, 1'b0, 1'b0);
      checkOutput("pp_count", 32'(count0), 32'd4);
    end
    checkOutput("pp_dropped", 32'(dropped0), 32'd2);
    checkOutput("pp_dropped_wrap", 32'(dropped1), 32'd2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pp_drain_pc", 32'(if0.out_pc), 32'(16'h005A + i));
      stepClock();
    end
    checkOutput("pp_drained", 32'(if0.out_valid), 32'd0);
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;

    // Halt freeze: the halt-cycle retirement is kept, later ones are not.
    applyStimulus(9'h001, 16'h006E, 16'h0001, 16'h0000, 1'b0, 1'b0);
    applyStimulus(9'h001, 16'h006F, 16'h0001, 16'h0000, 1'b0, 1'b0);
    applyStimulus(9'h001, 16'h0070, 16'h0001, 16'h0000, 1'b0, 1'b1);
    applyStimulus(9'h001, 16'h0071, 16'h0001, 16'h0000, 1'b0, 1'b0);
    applyStimulus(9'h003, 16'h0072, 16'h0001, 16'h0000, 1'b0, 1'b0);
    checkOutput("halt_frozen", 32'(frozen0), 32'd1);
    checkOutput("halt_count", 32'(count0), 32'd3);
    checkOutput("halt_illegal", 32'(illegal0), 32'd2);
    checkOutput("halt_head_pc", 32'(if0.out_pc), 32'h006E);
    popBoth();
    checkOutput("frz_pop_count", 32'(count0), 32'd2);
    checkOutput("frz_pop_pc", 32'(if0.out_pc), 32'h006F);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(if0.out_valid), 32'd0);
    checkOutput("arst_count", 32'(count0), 32'd0);
    checkOutput("arst_frozen", 32'(frozen0), 32'd0);
    checkOutput("arst_illegal", 32'(illegal0), 32'd0);
    checkOutput("arst_dropped_wrap", 32'(dropped1), 32'd0);
    stepClock();
    reset = 1'b0;
    stepClock();
    applyStimulus(9'h002, 16'h0080, 16'h0009, 16'hBEEF, 1'b0, 1'b0);
    checkOutput("post_valid", 32'(if0.out_valid), 32'd1);
    checkOutput("post_kind", 32'(if0.out_kind), 32'd1);
    checkOutput("post_addr", 32'(if0.out_addr), 32'h0009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
